// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch slice.
//   INSTR_W       : instruction word width
//   ADDR_W_DEF    : default PC / imem address width
//   RESET_PC_DEF  : default PC loaded on reset
//   OP_HALT       : opcode of the HALT instruction (decoded in execute)
//   fetch_state_t : fetch FSM state encoding
//   fetch_entry_t : one buffered instruction word with its PC
package cpu_pkg;

   localparam int          INSTR_W      = 32;
   localparam int          ADDR_W_DEF   = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h2000;
   localparam logic [4:0]  OP_HALT      = 5'h1F;

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0]    word;
      logic [ADDR_W_DEF-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used both as the instruction buffer and as the
// in-order request-PC tag queue.
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write din when push and not full
//   pop          : drop the head when pop and not empty
//   flush        : empty the FIFO (wins over push/pop in the same cycle)
//   dout         : head entry (valid only when !empty)
//   count        : number of stored entries
//   full, empty  : occupancy flags
// DEPTH must be a power of two, >= 2.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int        AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to imem, buffers
// returned words with their PC and hands them to decode.
//   clk, reset                     : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : read request channel (addr = PC)
//   imem_rsp_valid/data            : in-order read responses
//   instr_valid/ready, instr, instr_pc : buffered word toward decode
//   redirect_valid, redirect_pc    : load a new PC (branch / call / return)
//   halt                           : stop fetching
//   halted                         : FSM is in HALTED
//   fault                          : sticky, a misaligned redirect was seen
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high at the rising clock edge; valid never depends on the same channel's
// ready, and an offered request may be withdrawn only by redirect/halt.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
   parameter int                FIFO_DEPTH = 4,
   parameter int                MAX_OUTST  = 4
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [ADDR_W-1:0]   imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                halt,
   output logic                halted,
   output logic                fault
);

   localparam int          CW       = $clog2(MAX_OUTST + 1);
   localparam int          FCW      = $clog2(FIFO_DEPTH + 1);
   localparam int          EW       = INSTR_W + ADDR_W;
   localparam logic [31:0] DEPTH_U  = FIFO_DEPTH;
   localparam logic [31:0] OUTST_U  = MAX_OUTST;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     drop_q;
   logic              fault_q;

   logic              run, misaligned, halt_evt, redir_ok, flush_evt;
   logic              credit_ok, req_fire, rsp_keep, pop_head;

   logic [EW-1:0]     head_entry;
   logic [FCW-1:0]    fifo_count;
   logic              fifo_full, fifo_empty;
   logic [ADDR_W-1:0] tag_pc;
   logic [CW-1:0]     tag_count;
   logic              tag_full, tag_empty;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH_RUN;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (state_q == FETCH_RUN &&
          (halt || (redirect_valid && redirect_pc[1:0] != 2'b00)))
         state_d = FETCH_HALTED;
   end

   // ---------------- FSM: outputs / event decode ----------------
   always_comb begin
      run        = (state_q == FETCH_RUN);
      misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
      // Halt beats redirect; a misaligned redirect behaves like halt.
      halt_evt   = run && (halt || misaligned);
      redir_ok   = run && redirect_valid && !halt && !misaligned;
      flush_evt  = halt_evt || redir_ok;
      // Counting in-flight requests against free buffer space means every
      // response always has a slot waiting for it.
      credit_ok  = ((32'(outst_q) + 32'(fifo_count)) < DEPTH_U) &&
                   (32'(outst_q) < OUTST_U);
      imem_req_valid = run && !reset && credit_ok && !redirect_valid && !halt;
      instr_valid    = run && !fifo_empty;
      instr          = instr_valid ? head_entry[EW-1:ADDR_W] : '0;
      instr_pc       = instr_valid ? head_entry[ADDR_W-1:0]  : '0;
      halted         = !run;
   end

   assign imem_req_addr = pc_q;
   assign fault         = fault_q;

   assign req_fire = imem_req_valid && imem_req_ready;
   // A response is kept only when nothing stale is ahead of it and no
   // flush is happening this very cycle.
   assign rsp_keep = imem_rsp_valid && run && (drop_q == '0) && !flush_evt;
   assign pop_head = instr_valid && instr_ready;
   assign outst_d  = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         outst_q <= outst_d;
         // Everything still in flight after this cycle is stale.
         if (flush_evt)
            drop_q <= outst_d;
         else if (imem_rsp_valid && drop_q != '0)
            drop_q <= drop_q - CW'(1);
         if (redir_ok)
            pc_q <= redirect_pc;
         else if (req_fire)
            pc_q <= pc_q + ADDR_W'(4);
         if (run && misaligned && !halt)
            fault_q <= 1'b1;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_entry_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (rsp_keep),
      .din   ({imem_rsp_data, tag_pc}),
      .pop   (pop_head),
      .flush (flush_evt),
      .dout  (head_entry),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Holds the PC of every live request, oldest first.
   fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(ADDR_W)) u_tag_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (req_fire),
      .din   (pc_q),
      .pop   (rsp_keep),
      .flush (flush_evt),
      .dout  (tag_pc),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   a_rsp_needs_outst: assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (outst_q != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      rsp_keep |-> !fifo_full);
   a_tag_present: assert property (@(posedge clk) disable iff (reset)
      rsp_keep |-> !tag_empty);
   a_tag_room: assert property (@(posedge clk) disable iff (reset)
      req_fire |-> !tag_full);
   a_outst_split: assert property (@(posedge clk) disable iff (reset)
      32'(outst_q) == (32'(drop_q) + 32'(tag_count)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   localparam int ADDR_W = 64;

   logic              clk;
   logic              reset;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              halted;
   logic              fault;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // imem model / monitor state
   int                rsp_lat  = 1;
   logic              rsp_hold = 1'b0;
   int                cyc      = 0;
   logic [ADDR_W-1:0] pend_addr[$];
   int                pend_due[$];
   logic [ADDR_W-1:0] req_log[$];
   logic [ADDR_W-1:0] dlv_pc[$];
   logic [31:0]       dlv_word[$];

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted),
      .fault          (fault)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
      return a[31:0] ^ 32'hA5C3_0000;
   endfunction

   // imem responder and monitor, sampled on the falling edge. cyc is the
   // index of the upcoming rising edge.
   always @(negedge clk) begin
      if (reset) begin
         pend_addr.delete();
         pend_due.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         cyc = cyc + 1;
         if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + rsp_lat);
            req_log.push_back(imem_req_addr);
         end
         if (instr_valid && instr_ready) begin
            dlv_pc.push_back(instr_pc);
            dlv_word.push_back(instr);
         end
         if (!rsp_hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      rsp_hold       = 1'b0;
      rsp_lat        = 1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Compare delivered words (from index base) with exp_q.
   task automatic check_deliveries(input string name, input int base,
                                   input logic [ADDR_W-1:0] first, input int n);
      logic [ADDR_W-1:0] exp_q[$];
      logic [ADDR_W-1:0] e;
      for (int i = 0; i < n; i++) exp_q.push_back(first + 64'(4 * i));
      chk_cnt++;
      if (dlv_pc.size() < base + n)
         $display("FAIL %s_count: got %0d deliveries, expected at least %0d",
                  name, dlv_pc.size() - base, n);
      else begin
         pass_cnt++;
         for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (dlv_pc[base+i] !== e || dlv_word[base+i] !== word_of(e))
               $display("FAIL %s[%0d]: got pc %h word %h, expected pc %h word %h",
                        name, i, dlv_pc[base+i], dlv_word[base+i], e, word_of(e));
            else pass_cnt++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      tick();
      tick();
      chk_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
      chk_cnt++; if (imem_req_addr !== 64'h2000) $display("FAIL rst_req_addr: got %h expected 2000", imem_req_addr); else pass_cnt++;
      chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
      chk_cnt++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", instr); else pass_cnt++;
      chk_cnt++; if (instr_pc !== 64'h0) $display("FAIL rst_instr_pc: got %h expected 0", instr_pc); else pass_cnt++;
      chk_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted); else pass_cnt++;
      chk_cnt++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", fault); else pass_cnt++;
   endtask

   task automatic test_stream();
      logic [ADDR_W-1:0] exp_pc;
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      #1;
      chk_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000)
         $display("FAIL stream_first_req: got valid %b addr %h expected 1 2000", imem_req_valid, imem_req_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL stream_latency: got instr_valid %b expected 0", instr_valid); else pass_cnt++;
      for (int k = 2; k < 10; k++) begin
         tick();
         exp_pc = 64'h2000 + 64'(4 * (k - 2));
         chk_cnt++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== word_of(exp_pc))
            $display("FAIL stream_word[%0d]: got v %b pc %h w %h expected 1 %h %h",
                     k, instr_valid, instr_pc, instr, exp_pc, word_of(exp_pc));
         else pass_cnt++;
         chk_cnt++;
         if (imem_req_addr !== 64'h2000 + 64'(4 * k))
            $display("FAIL stream_addr[%0d]: got %h expected %h", k, imem_req_addr, 64'h2000 + 64'(4 * k));
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int base_r, base_d;
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      base_r = req_log.size();
      base_d = dlv_pc.size();
      repeat (10) tick();
      chk_cnt++; if (req_log.size() - base_r != 4)
         $display("FAIL bp_req_count: got %0d expected 4", req_log.size() - base_r); else pass_cnt++;
      chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 64'h2000)
         $display("FAIL bp_head: got v %b pc %h expected 1 2000", instr_valid, instr_pc); else pass_cnt++;
      chk_cnt++; if (imem_req_valid !== 1'b0)
         $display("FAIL bp_no_credit: got req_valid %b expected 0", imem_req_valid); else pass_cnt++;
      instr_ready = 1'b1;
      repeat (16) tick();
      check_deliveries("bp_order", base_d, 64'h2000, 6);
   endtask

   task automatic test_redirect_drop();
      int base_r, base_d;
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      rsp_hold       = 1'b1;
      base_r = req_log.size();
      base_d = dlv_pc.size();
      repeat (3) tick();
      chk_cnt++; if (req_log.size() - base_r != 3)
         $display("FAIL rd_inflight: got %0d expected 3", req_log.size() - base_r); else pass_cnt++;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      rsp_hold       = 1'b0;
      #1;
      chk_cnt++; if (imem_req_valid !== 1'b0)
         $display("FAIL rd_no_issue: got req_valid %b expected 0", imem_req_valid); else pass_cnt++;
      tick();
      redirect_valid = 1'b0;
      chk_cnt++; if (imem_req_addr !== 64'h3000)
         $display("FAIL rd_pc: got %h expected 3000", imem_req_addr); else pass_cnt++;
      repeat (12) tick();
      chk_cnt++; if (req_log.size() < base_r + 4 || req_log[base_r+3] !== 64'h3000)
         $display("FAIL rd_first_fetch: got %0d reqs, expected 4th at 3000", req_log.size() - base_r); else pass_cnt++;
      check_deliveries("rd_deliv", base_d, 64'h3000, 4);
   endtask

   task automatic test_halt_redirect();
      int base_r;
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      halt           = 1'b1;
      #1;
      chk_cnt++; if (halted !== 1'b0 || imem_req_valid !== 1'b0)
         $display("FAIL hr_same_cycle: got halted %b req_valid %b expected 0 0", halted, imem_req_valid); else pass_cnt++;
      tick();
      redirect_valid = 1'b0;
      halt           = 1'b0;
      base_r = req_log.size();
      chk_cnt++; if (halted !== 1'b1) $display("FAIL hr_halted: got %b expected 1", halted); else pass_cnt++;
      chk_cnt++; if (imem_req_addr !== 64'h200c) $display("FAIL hr_pc_held: got %h expected 200c", imem_req_addr); else pass_cnt++;
      chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL hr_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
      chk_cnt++; if (fault !== 1'b0) $display("FAIL hr_fault: got %b expected 0", fault); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++; if (imem_req_valid !== 1'b0 || halted !== 1'b1)
            $display("FAIL hr_stay[%0d]: got req_valid %b halted %b expected 0 1", i, imem_req_valid, halted); else pass_cnt++;
      end
      chk_cnt++; if (req_log.size() != base_r)
         $display("FAIL hr_no_req: got %0d new requests expected 0", req_log.size() - base_r); else pass_cnt++;
   endtask

   task automatic test_misaligned();
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3002;
      #1;
      chk_cnt++; if (fault !== 1'b0) $display("FAIL mis_fault_early: got %b expected 0", fault); else pass_cnt++;
      tick();
      redirect_valid = 1'b0;
      chk_cnt++; if (fault !== 1'b1 || halted !== 1'b1)
         $display("FAIL mis_state: got fault %b halted %b expected 1 1", fault, halted); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_cnt++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || fault !== 1'b1)
            $display("FAIL mis_stay[%0d]: got iv %b rv %b fault %b expected 0 0 1", i, instr_valid, imem_req_valid, fault);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_midburst();
      int base_r, base_d;
      do_reset();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      repeat (3) tick();
      chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 64'h2000)
         $display("FAIL mr_before: got v %b pc %h expected 1 2000", instr_valid, instr_pc); else pass_cnt++;
      #1 reset = 1'b1;
      #1;
      chk_cnt++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 64'h2000 || halted !== 1'b0)
         $display("FAIL mr_async: got iv %b rv %b addr %h halted %b expected 0 0 2000 0",
                  instr_valid, imem_req_valid, imem_req_addr, halted);
      else pass_cnt++;
      tick();
      tick();
      reset       = 1'b0;
      instr_ready = 1'b1;
      base_r = req_log.size();
      base_d = dlv_pc.size();
      repeat (6) tick();
      chk_cnt++; if (req_log.size() <= base_r || req_log[base_r] !== 64'h2000)
         $display("FAIL mr_restart: got %0d reqs, expected first at 2000", req_log.size() - base_r); else pass_cnt++;
      check_deliveries("mr_deliv", base_d, 64'h2000, 3);
   endtask

   task automatic test_pc_wrap();
      int base_d;
      do_reset();
      imem_req_ready = 1'b0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      base_d = dlv_pc.size();
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      #1;
      chk_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
         $display("FAIL wrap_top: got v %b addr %h expected 1 fffffffffffffffc", imem_req_valid, imem_req_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (imem_req_addr !== 64'h0)
         $display("FAIL wrap_zero: got %h expected 0", imem_req_addr); else pass_cnt++;
      repeat (4) tick();
      check_deliveries("wrap_deliv", base_d, 64'hFFFF_FFFF_FFFF_FFFC, 3);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_halt_redirect();
      test_misaligned();
      test_reset_midburst();
      test_pc_wrap();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
